ddr_app_responder: RTL and testbench

- Synthesizable responder for the DDR3 controller user (app) interface. It stands in for the memory IP so that app-side traffic generators can be simulated and run on hardware without a PHY.
- It accepts app_en / app_cmd / app_addr commands and app_wdf_* write data, and commits writes with byte masking into a small register-file backing store.
- It returns read data with a fixed latency and in order.
- It models calibration delay, command back-pressure and read-after-write ordering.

---
 rtl/ddr_app_if.sv | 33 +++
 rtl/ddr_app_responder.sv | 176 +++++++++++++++++
 tb/tb_ddr_app_responder.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/ddr_app_if.sv
// DDR3 controller user (app) interface bundle.
// master: traffic generator side (drives commands and write data).
// slave:  memory / responder side (drives ready, read data).
// Signals: app_en/app_cmd/app_addr/app_rdy command channel,
//          app_wdf_* write-data channel, app_rd_data* read-return channel.
interface ddr_app_if #(
  parameter int unsigned ADDR_WIDTH     = 28,
  parameter int unsigned APP_DATA_WIDTH = 256,
  parameter int unsigned APP_MASK_WIDTH = 32
);
  logic                      app_en;
  logic [2:0]                app_cmd;
  logic [ADDR_WIDTH-1:0]     app_addr;
  logic                      app_rdy;
  logic [APP_DATA_WIDTH-1:0] app_wdf_data;
  logic [APP_MASK_WIDTH-1:0] app_wdf_mask;
  logic                      app_wdf_wren;
  logic                      app_wdf_end;
  logic                      app_wdf_rdy;
  logic [APP_DATA_WIDTH-1:0] app_rd_data;
  logic                      app_rd_data_valid;
  logic                      app_rd_data_end;

  modport master (
    output app_en, app_cmd, app_addr, app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end,
    input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end
  );

  modport slave (
    input  app_en, app_cmd, app_addr, app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end,
    output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end
  );
endinterface

// File: rtl/ddr_app_responder.sv
// Stand-in for the DDR3 memory IP on the app interface.
// Accepts write/read commands and write data, commits byte-masked writes into a small
// register-file store, and returns read data in order after a fixed latency.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   app                 ddr_app_if slave modport (command, write data, read return)
//   init_calib_complete high CALIB_CYCLES cycles after reset release
//   proto_err           sticky: invalid command or write beat without app_wdf_end
module ddr_app_responder #(
  parameter int unsigned ADDR_WIDTH     = 28,
  parameter int unsigned APP_DATA_WIDTH = 256,
  parameter int unsigned APP_MASK_WIDTH = 32,
  parameter int unsigned MEM_DEPTH_LOG2 = 4,
  parameter int unsigned CALIB_CYCLES   = 16,
  parameter int unsigned RD_LATENCY     = 4,
  parameter int unsigned WQ_DEPTH       = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  ddr_app_if.slave  app,
  output logic      init_calib_complete,
  output logic      proto_err
);

  localparam int unsigned Depth = 1 << MEM_DEPTH_LOG2;
  localparam int unsigned CntW  = $clog2(WQ_DEPTH + 1);
  localparam int unsigned PtrW  = (WQ_DEPTH > 1) ? $clog2(WQ_DEPTH) : 1;
  localparam int unsigned CalW  = $clog2(CALIB_CYCLES + 1);
  localparam int unsigned WdW   = APP_DATA_WIDTH + APP_MASK_WIDTH;
  localparam logic [CntW-1:0] QFull  = CntW'(WQ_DEPTH);
  localparam logic [PtrW-1:0] PtrMax = PtrW'(WQ_DEPTH - 1);
  localparam logic [2:0] CmdWrite = 3'b000;
  localparam logic [2:0] CmdRead  = 3'b001;

  typedef logic [MEM_DEPTH_LOG2-1:0] idx_t;
  typedef logic [APP_DATA_WIDTH-1:0] line_t;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrMax) ? '0 : p + PtrW'(1);
  endfunction

  // Storage
  line_t           mem_q [Depth];
  idx_t            wcmd_q [WQ_DEPTH];
  logic [WdW-1:0]  wdata_q [WQ_DEPTH];
  line_t           pipe_data_q [RD_LATENCY];
  logic [RD_LATENCY-1:0] pipe_valid_q;

  // Control state
  logic [PtrW-1:0] wcmd_wr_q, wcmd_rd_q, wdata_wr_q, wdata_rd_q;
  logic [CntW-1:0] wcmd_cnt_q, wdata_cnt_q;
  logic [CalW-1:0] calib_cnt_q;
  logic            calib_done_q, app_rdy_q, wdf_rdy_q, proto_err_q;
  logic            rd_hold_valid_q;
  idx_t            rd_hold_idx_q;

  // Next-state / decode
  logic            cmd_acc, wr_acc, rd_acc, bad_acc, beat_acc, commit;
  logic            issue_new, hold_set, hold_issue, issue;
  logic            calib_done_d, rd_hold_valid_d;
  logic [CntW-1:0] wcmd_after, wcmd_cnt_d, wdata_cnt_d;
  idx_t            acc_idx, commit_idx, issue_idx;
  line_t           commit_data, commit_line, issue_data;
  logic [APP_MASK_WIDTH-1:0] commit_mask;
  logic            unused_addr;

  assign acc_idx     = app.app_addr[MEM_DEPTH_LOG2+2:3];
  assign unused_addr = ^{app.app_addr[ADDR_WIDTH-1:MEM_DEPTH_LOG2+3], app.app_addr[2:0]};

  assign cmd_acc  = app.app_en & app_rdy_q;
  assign wr_acc   = cmd_acc & (app.app_cmd == CmdWrite);
  assign rd_acc   = cmd_acc & (app.app_cmd == CmdRead);
  assign bad_acc  = cmd_acc & (app.app_cmd != CmdWrite) & (app.app_cmd != CmdRead);
  assign beat_acc = app.app_wdf_wren & wdf_rdy_q;
  assign commit   = (wcmd_cnt_q != '0) & (wdata_cnt_q != '0);

  assign commit_idx                 = wcmd_q[wcmd_rd_q];
  assign {commit_data, commit_mask} = wdata_q[wdata_rd_q];

  // Mask bit set = keep the stored byte
  always_comb begin
    commit_line = mem_q[commit_idx];
    for (int b = 0; b < APP_MASK_WIDTH; b++) begin
      if (!commit_mask[b]) commit_line[8*b +: 8] = commit_data[8*b +: 8];
    end
  end

  // Reads wait until every write command ahead of them has committed; the commit in the
  // issuing cycle is forwarded so the read sees it.
  always_comb begin
    wcmd_after      = wcmd_cnt_q - CntW'(commit);
    wcmd_cnt_d      = wcmd_after + CntW'(wr_acc);
    wdata_cnt_d     = wdata_cnt_q - CntW'(commit) + CntW'(beat_acc);
    issue_new       = rd_acc & (wcmd_after == '0);
    hold_set        = rd_acc & (wcmd_after != '0);
    hold_issue      = rd_hold_valid_q & (wcmd_after == '0);
    issue           = issue_new | hold_issue;
    issue_idx       = hold_issue ? rd_hold_idx_q : acc_idx;
    issue_data      = (commit && (commit_idx == issue_idx)) ? commit_line : mem_q[issue_idx];
    rd_hold_valid_d = hold_set | (rd_hold_valid_q & ~hold_issue);
    calib_done_d    = calib_done_q | (calib_cnt_q == CalW'(CALIB_CYCLES - 1));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      calib_cnt_q     <= '0;
      calib_done_q    <= 1'b0;
      app_rdy_q       <= 1'b0;
      wdf_rdy_q       <= 1'b0;
      proto_err_q     <= 1'b0;
      wcmd_wr_q       <= '0;
      wcmd_rd_q       <= '0;
      wdata_wr_q      <= '0;
      wdata_rd_q      <= '0;
      wcmd_cnt_q      <= '0;
      wdata_cnt_q     <= '0;
      rd_hold_valid_q <= 1'b0;
      rd_hold_idx_q   <= '0;
    end else begin
      if (!calib_done_q) calib_cnt_q <= calib_cnt_q + CalW'(1);
      calib_done_q    <= calib_done_d;
      // Ready flags come from next-state values: no path from app_en to app_rdy.
      app_rdy_q       <= calib_done_d & (wcmd_cnt_d < QFull) & ~rd_hold_valid_d;
      wdf_rdy_q       <= calib_done_d & (wdata_cnt_d < QFull);
      if (bad_acc || (beat_acc && !app.app_wdf_end)) proto_err_q <= 1'b1;
      if (wr_acc)   wcmd_wr_q  <= ptr_inc(wcmd_wr_q);
      if (beat_acc) wdata_wr_q <= ptr_inc(wdata_wr_q);
      if (commit) begin
        wcmd_rd_q  <= ptr_inc(wcmd_rd_q);
        wdata_rd_q <= ptr_inc(wdata_rd_q);
      end
      wcmd_cnt_q      <= wcmd_cnt_d;
      wdata_cnt_q     <= wdata_cnt_d;
      rd_hold_valid_q <= rd_hold_valid_d;
      if (hold_set) rd_hold_idx_q <= acc_idx;
    end
  end

  // Queue payloads need no reset; pointers and counts define what is live.
  always_ff @(posedge clk) begin
    if (wr_acc)   wcmd_q[wcmd_wr_q]   <= acc_idx;
    if (beat_acc) wdata_q[wdata_wr_q] <= {app.app_wdf_data, app.app_wdf_mask};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else if (commit) begin
      mem_q[commit_idx] <= commit_line;
    end
  end

  // Data stages only load behind a valid, so the last stage holds the previous read.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pipe_valid_q <= '0;
      for (int i = 0; i < RD_LATENCY; i++) pipe_data_q[i] <= '0;
    end else begin
      pipe_valid_q[0] <= issue;
      if (issue) pipe_data_q[0] <= issue_data;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_valid_q[i] <= pipe_valid_q[i-1];
        if (pipe_valid_q[i-1]) pipe_data_q[i] <= pipe_data_q[i-1];
      end
    end
  end

  assign app.app_rdy           = app_rdy_q;
  assign app.app_wdf_rdy       = wdf_rdy_q;
  assign app.app_rd_data       = pipe_data_q[RD_LATENCY-1];
  assign app.app_rd_data_valid = pipe_valid_q[RD_LATENCY-1];
  assign app.app_rd_data_end   = pipe_valid_q[RD_LATENCY-1];
  assign init_calib_complete   = calib_done_q;
  assign proto_err             = proto_err_q;

endmodule

// File: tb/tb_ddr_app_responder.sv
// Directed bench for ddr_app_responder: calibration, masked writes, ordering,
// back-pressure, data-before-command, protocol errors and mid-flight reset.
module tb_ddr_app_responder;

  logic clk = 1'b0;
  logic rst_n;
  logic icc, perr;
  int   checks = 0;
  int   errors = 0;
  int   vcount = 0;

  ddr_app_if app_bus ();

  ddr_app_responder dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .app                 (app_bus),
    .init_calib_complete (icc),
    .proto_err           (perr)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (app_bus.app_rd_data_valid) vcount++;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [2:0] cmd, input logic [27:0] addr);
    int n = 0;
    app_bus.app_en   = 1'b1;
    app_bus.app_cmd  = cmd;
    app_bus.app_addr = addr;
    while (!app_bus.app_rdy && n < 100) begin step(); n++; end
    if (n >= 100) check("cmd_accept_timeout", 0, 1);
    step();
    app_bus.app_en = 1'b0;
  endtask

  task automatic send_beat(input logic [255:0] d, input logic [31:0] m, input logic e);
    int n = 0;
    app_bus.app_wdf_wren = 1'b1;
    app_bus.app_wdf_data = d;
    app_bus.app_wdf_mask = m;
    app_bus.app_wdf_end  = e;
    while (!app_bus.app_wdf_rdy && n < 100) begin step(); n++; end
    if (n >= 100) check("wdf_accept_timeout", 0, 1);
    step();
    app_bus.app_wdf_wren = 1'b0;
    app_bus.app_wdf_end  = 1'b0;
  endtask

  // n counts cycles from the accepting edge of the read (that edge counts as 1).
  task automatic wait_valid(output logic [255:0] d, output int n);
    n = 1;
    while (!app_bus.app_rd_data_valid && n < 64) begin step(); n++; end
    d = app_bus.app_rd_data;
    if (n >= 64) check("rd_valid_timeout", 0, 1);
  endtask

  task automatic wait_calib();
    int n = 0;
    while (!icc && n < 64) begin step(); n++; end
    if (n >= 64) check("calib_timeout", 0, 1);
  endtask

  task automatic read_entry(input string tag, input logic [27:0] addr, input logic [255:0] exp);
    logic [255:0] d;
    int           n;
    send_cmd(3'b001, addr);
    wait_valid(d, n);
    check(tag, d, exp);
  endtask

  logic [255:0] d1, d5, d6, d7, rd;
  logic [255:0] dw [4];
  int           lat, icc_rise, rdy_rise, vbase;

  initial begin
    d1 = 256'h0123456789abcdef_fedcba9876543210_a5a5a5a5_5a5a5a5a_5883adb4c88ad596;
    d5 = {4{64'hdeadbeef_00000005}};
    d6 = {4{64'hcafef00d_00000006}};
    d7 = {8{32'h77770007}};
    for (int k = 0; k < 4; k++) dw[k] = {32{8'(8'h41 + k)}};

    rst_n                = 1'b0;
    app_bus.app_en       = 1'b0;
    app_bus.app_cmd      = 3'b000;
    app_bus.app_addr     = '0;
    app_bus.app_wdf_data = '0;
    app_bus.app_wdf_mask = '0;
    app_bus.app_wdf_wren = 1'b0;
    app_bus.app_wdf_end  = 1'b0;
    repeat (3) step();
    check("reset_flags", {app_bus.app_rdy, app_bus.app_wdf_rdy, app_bus.app_rd_data_valid,
                          app_bus.app_rd_data_end, icc, perr}, 6'b0);
    check("reset_rd_data", app_bus.app_rd_data, '0);

    // Calibration: app_en held high throughout; nothing may be accepted early.
    app_bus.app_en  = 1'b1;
    app_bus.app_cmd = 3'b001;
    rst_n           = 1'b1;
    icc_rise        = 0;
    rdy_rise        = 0;
    for (int k = 1; k <= 16; k++) begin
      step();
      if (icc && icc_rise == 0) icc_rise = k;
      if (app_bus.app_rdy && rdy_rise == 0) rdy_rise = k;
    end
    app_bus.app_en = 1'b0;
    check("calib_rise_cycle", icc_rise, 16);
    check("rdy_rise_cycle", rdy_rise, 16);
    check("wdf_rdy_after_calib", app_bus.app_wdf_rdy, 1);

    // Unmasked write then read of addr 0x8 (entry 1)
    send_cmd(3'b000, 28'h0000008);
    send_beat(d1, 32'h0, 1'b1);
    send_cmd(3'b001, 28'h0000008);
    wait_valid(rd, lat);
    check("rd_latency", lat, 4);
    check("rd_data_unmasked", rd, d1);
    check("rd_data_end", app_bus.app_rd_data_end, 1);
    step();
    check("rd_valid_one_pulse", app_bus.app_rd_data_valid, 0);
    check("rd_data_held", app_bus.app_rd_data, d1);

    // Byte mask on entry 2
    send_cmd(3'b000, 28'h0000010);
    send_beat({256{1'b1}}, 32'h0, 1'b1);
    send_cmd(3'b000, 28'h0000010);
    send_beat('0, 32'h0000000F, 1'b1);
    read_entry("rd_byte_mask", 28'h0000010, {224'h0, 32'hFFFFFFFF});

    // Ordering / back-pressure: 4 commands to entries 10..13 with no data yet
    for (int k = 0; k < 4; k++) send_cmd(3'b000, 28'((10 + k) << 3));
    check("rdy_low_queue_full", app_bus.app_rdy, 0);
    vbase = vcount;
    repeat (4) step();
    check("no_valid_while_blocked", vcount, vbase);
    fork
      send_cmd(3'b001, 28'(13 << 3));
      for (int k = 0; k < 4; k++) send_beat(dw[k], 32'h0, 1'b1);
    join
    wait_valid(rd, lat);
    check("held_read_sees_last_write", rd, dw[3]);
    step();
    check("rdy_back_after_hold", app_bus.app_rdy, 1);
    read_entry("rd_entry10", 28'(10 << 3), dw[0]);

    // Data before command: entries 5 and 6
    send_beat(d5, 32'h0, 1'b1);
    send_beat(d6, 32'h0, 1'b1);
    send_cmd(3'b000, 28'(5 << 3));
    send_cmd(3'b000, 28'(6 << 3));
    check("proto_err_clean", perr, 0);

    // Back-to-back reads -> back-to-back valids, then data held
    send_cmd(3'b001, 28'(5 << 3));
    send_cmd(3'b001, 28'(6 << 3));
    step();
    step();
    check("b2b_valid0", app_bus.app_rd_data_valid, 1);
    check("b2b_data0", app_bus.app_rd_data, d5);
    step();
    check("b2b_valid1", app_bus.app_rd_data_valid, 1);
    check("b2b_data1", app_bus.app_rd_data, d6);
    step();
    check("b2b_valid_done", app_bus.app_rd_data_valid, 0);
    check("b2b_data_held", app_bus.app_rd_data, d6);

    // Invalid command is dropped and sets proto_err
    send_cmd(3'b011, 28'(5 << 3));
    step();
    check("proto_err_bad_cmd", perr, 1);
    read_entry("bad_cmd_no_write", 28'(5 << 3), d5);

    // Reset with two reads in flight
    send_cmd(3'b001, 28'(5 << 3));
    send_cmd(3'b001, 28'(6 << 3));
    vbase = vcount;
    rst_n = 1'b0;
    step();
    check("midreset_flags", {app_bus.app_rdy, app_bus.app_wdf_rdy, app_bus.app_rd_data_valid,
                             app_bus.app_rd_data_end, icc, perr}, 6'b0);
    check("midreset_rd_data", app_bus.app_rd_data, '0);
    repeat (3) step();
    rst_n = 1'b1;
    wait_calib();
    step();
    check("no_valid_across_reset", vcount, vbase);
    read_entry("entry5_cleared", 28'(5 << 3), '0);

    // Beat without app_wdf_end: flagged but still stored
    send_beat(d7, 32'h0, 1'b0);
    send_cmd(3'b000, 28'(7 << 3));
    check("proto_err_no_end", perr, 1);
    read_entry("no_end_beat_stored", 28'(7 << 3), d7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
